// File: rtl/reg_write_arbiter_if.sv
// Bus bundle for reg_write_arbiter: requester-side request/data and the
// arbiter's grant, shared register, owner, busy and timeout outputs.
interface reg_write_arbiter_if;
    logic [3:0]  req;
    logic [15:0] din;
    logic [3:0]  gnt;
    logic [3:0]  q;
    logic [1:0]  owner;
    logic        busy;
    logic        timeout;

    modport master (
        output req, din,
        input  gnt, q, owner, busy, timeout
    );

    modport slave (
        input  req, din,
        output gnt, q, owner, busy, timeout
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter for a shared 4-bit register with four requesters.
// Optional forced-release timeout is built only when REG_ARB_TIMEOUT_EN is defined.
module reg_write_arbiter #(
    parameter int TIMEOUT_CYC = 15
) (
    input logic               clk,
    input logic               clr,
    reg_write_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        WAIT_REL = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  gnt_q, gnt_d;
    logic [3:0]  q_q, q_d;
    logic [1:0]  owner_q, owner_d;
    logic [1:0]  ptr_q, ptr_d;
    logic        timeout_q, timeout_d;

    logic        win_found;
    logic [1:0]  win_idx;
    logic [1:0]  cand;

`ifdef REG_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) + 1 : 1;
    logic [CW-1:0] cnt_q, cnt_d;
`else
    // Parameter only matters with the timeout compiled in; reduce it so it is referenced.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

    // Round-robin search starting at ptr_q; first set request wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        q_d       = q_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        timeout_d = 1'b0;
`ifdef REG_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (win_found) begin
                    owner_d = win_idx;
                    gnt_d   = 4'b0001 << win_idx;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                q_d     = bus.din[{owner_q, 2'b00} +: 4];
                state_d = WAIT_REL;
`ifdef REG_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT_REL: begin
                if (!bus.req[owner_q]) begin
                    gnt_d   = '0;
                    ptr_d   = owner_q + 2'd1;
                    state_d = IDLE;
                end
`ifdef REG_ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    gnt_d     = '0;
                    ptr_d     = owner_q + 2'd1;
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            q_q       <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            q_q       <= q_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef REG_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (clr) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`endif

    assign bus.gnt     = gnt_q;
    assign bus.q       = q_q;
    assign bus.owner   = owner_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: expected register values are queued
// when a write is requested and popped when the arbiter performs its load.
module tb_reg_write_arbiter;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    reg_write_arbiter_if bus ();

    reg_write_arbiter #(.TIMEOUT_CYC(15)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    int passed = 0;
    int total  = 0;
    int onehot_err = 0;
    logic [3:0] exp_q_fifo[$];

    always @(negedge clk) if (!$onehot0(bus.gnt)) onehot_err++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_load(input string name);
        logic [3:0] e;
        total++;
        if (exp_q_fifo.size() == 0) begin
            $display("FAIL %s: scoreboard empty, q got %h", name, bus.q);
        end else begin
            e = exp_q_fifo.pop_front();
            if (bus.q !== e) $display("FAIL %s: q got %h want %h", name, bus.q, e);
            else passed++;
        end
    endtask

    task automatic test_reset();
        clr = 1'b1; bus.req = '0; bus.din = '0;
        tick(); tick();
        clr = 1'b0;
        total++;
        if ({bus.gnt, bus.q, bus.owner, bus.busy, bus.timeout} !== 12'h000)
            $display("FAIL reset: gnt=%b q=%h owner=%0d busy=%b timeout=%b want all 0",
                     bus.gnt, bus.q, bus.owner, bus.busy, bus.timeout);
        else passed++;
    endtask

    task automatic test_single();
        bus.req = 4'b0001; bus.din = 16'h0005;
        exp_q_fifo.push_back(4'h5);
        tick();
        total++;
        if (bus.gnt !== 4'b0001 || bus.busy !== 1'b1 || bus.q !== 4'h0)
            $display("FAIL single_grant: gnt=%b busy=%b q=%h want 0001/1/0", bus.gnt, bus.busy, bus.q);
        else passed++;
        tick();
        check_load("single_load");
        bus.req = 4'b0000;
        tick();
        total++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0)
            $display("FAIL single_release: gnt=%b busy=%b want 0000/0", bus.gnt, bus.busy);
        else passed++;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_owner[$];
        logic [1:0] eo;
        logic [15:0] d;
        clr = 1'b1; tick(); clr = 1'b0;
        d = 16'hABCD;
        bus.din = d;
        bus.req = 4'b1111;
        exp_owner = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        foreach (exp_owner[k]) exp_q_fifo.push_back(d[{exp_owner[k], 2'b00} +: 4]);
        for (int n = 0; n < 5; n++) begin
            eo = exp_owner.pop_front();
            tick();
            total++;
            if (bus.gnt !== (4'b0001 << eo) || bus.owner !== eo)
                $display("FAIL rr_grant%0d: gnt=%b owner=%0d want owner %0d", n, bus.gnt, bus.owner, eo);
            else passed++;
            tick();
            check_load("rr_load");
            bus.req[eo] = 1'b0;
            tick();
            total++;
            if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0)
                $display("FAIL rr_release%0d: gnt=%b busy=%b want 0000/0", n, bus.gnt, bus.busy);
            else passed++;
            bus.req = 4'b1111;
        end
        bus.req = 4'b0000;
        tick();
    endtask

    task automatic test_early_drop();
        int gnt_hi;
        gnt_hi = 0;
        bus.req = 4'b0100; bus.din = 16'h0900;
        exp_q_fifo.push_back(4'h9);
        tick();
        if (bus.gnt != 0) gnt_hi++;
        bus.req = 4'b0000;
        tick();
        if (bus.gnt != 0) gnt_hi++;
        check_load("early_load");
        for (int n = 0; n < 3; n++) begin
            tick();
            if (bus.gnt != 0) gnt_hi++;
        end
        total++;
        if (gnt_hi !== 2 || bus.busy !== 1'b0 || bus.owner !== 2'd2)
            $display("FAIL early_drop: gnt cycles=%0d busy=%b owner=%0d want 2/0/2", gnt_hi, bus.busy, bus.owner);
        else passed++;
    endtask

    task automatic test_reset_mid();
        bus.req = 4'b0001; bus.din = 16'h000F;
        tick();
        total++;
        if (bus.gnt !== 4'b0001)
            $display("FAIL midrst_grant: gnt=%b want 0001", bus.gnt);
        else passed++;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        bus.req = 4'b0000;
        total++;
        if (bus.q !== 4'h0 || bus.gnt !== 4'b0000 || bus.owner !== 2'd0 || bus.busy !== 1'b0)
            $display("FAIL midrst_abort: q=%h gnt=%b owner=%0d busy=%b want 0/0000/0/0",
                     bus.q, bus.gnt, bus.owner, bus.busy);
        else passed++;
        bus.req = 4'b0010; bus.din = 16'h0070;
        exp_q_fifo.push_back(4'h7);
        tick();
        total++;
        if (bus.gnt !== 4'b0010 || bus.owner !== 2'd1)
            $display("FAIL midrst_regrant: gnt=%b owner=%0d want 0010/1", bus.gnt, bus.owner);
        else passed++;
        tick();
        check_load("midrst_load");
        bus.req = 4'b0000;
        tick();
    endtask

`ifdef REG_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        int pulses;
        clr = 1'b1; tick(); clr = 1'b0;
        bus.req = 4'b0001; bus.din = 16'h3002;
        exp_q_fifo.push_back(4'h2);
        tick();
        tick();
        check_load("to_load");
        bus.req = 4'b1001;
        n = 0;
        while (bus.timeout !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        total++;
        if (n !== 15 || bus.gnt !== 4'b0000)
            $display("FAIL to_pulse: waited %0d cycles gnt=%b want 15/0000", n, bus.gnt);
        else passed++;
        pulses = 1;
        tick();
        if (bus.timeout === 1'b1) pulses++;
        total++;
        if (bus.gnt !== 4'b1000 || bus.owner !== 2'd3)
            $display("FAIL to_regrant: gnt=%b owner=%0d want 1000/3", bus.gnt, bus.owner);
        else passed++;
        exp_q_fifo.push_back(4'h3);
        tick();
        if (bus.timeout === 1'b1) pulses++;
        check_load("to_load3");
        bus.req = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (bus.timeout === 1'b1) pulses++;
        end
        total++;
        if (pulses !== 1)
            $display("FAIL to_once: pulses=%0d want 1", pulses);
        else passed++;
    endtask
`else
    task automatic test_no_timeout();
        int bad_gnt;
        int bad_to;
        bad_gnt = 0; bad_to = 0;
        bus.req = 4'b0001; bus.din = 16'h0004;
        exp_q_fifo.push_back(4'h4);
        tick();
        tick();
        check_load("nto_load");
        bus.req = 4'b1001;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.gnt !== 4'b0001) bad_gnt++;
            if (bus.timeout !== 1'b0) bad_to++;
        end
        total++;
        if (bad_gnt !== 0 || bad_to !== 0)
            $display("FAIL nto_hold: bad gnt cycles=%0d timeout cycles=%0d want 0/0", bad_gnt, bad_to);
        else passed++;
        bus.req = 4'b1000;
        tick();
        total++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0)
            $display("FAIL nto_release: gnt=%b busy=%b want 0000/0", bus.gnt, bus.busy);
        else passed++;
        tick();
        total++;
        if (bus.gnt !== 4'b1000 || bus.owner !== 2'd3)
            $display("FAIL nto_next: gnt=%b owner=%0d want 1000/3", bus.gnt, bus.owner);
        else passed++;
        bus.req = 4'b0000;
        tick(); tick();
        void'(exp_q_fifo.size());
        exp_q_fifo.push_back(4'h0);
        exp_q_fifo.delete(exp_q_fifo.size() - 1);
    endtask
`endif

    initial begin
        bus.req = '0;
        bus.din = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_early_drop();
        test_reset_mid();
`ifdef REG_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        total++;
        if (onehot_err !== 0)
            $display("FAIL gnt_onehot: violations=%0d want 0", onehot_err);
        else passed++;
        total++;
        if (exp_q_fifo.size() !== 0)
            $display("FAIL scoreboard_drain: leftover=%0d want 0", exp_q_fifo.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
